// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: BTB sizing default, 2-bit counter
// encodings and the bubble instruction.
package fetch_pkg;

  localparam int DEFAULT_BTB_ENTRIES = 16;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } counter_t;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0;

  // Saturating step of a 2-bit direction counter toward the resolved outcome.
  function automatic counter_t next_count(counter_t c, logic taken);
    if (taken) return (c == STRONG_T) ? STRONG_T : counter_t'(c + 2'd1);
    else return (c == STRONG_NT) ? STRONG_NT : counter_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/btb_2bit.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on the current PC; updates land on the clock edge.
module btb_2bit
  import fetch_pkg::*;
#(
  parameter int ENTRIES = DEFAULT_BTB_ENTRIES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] lookup_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output counter_t    pred_count
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 32 - IW - 2;

  logic             valid_q  [ENTRIES];
  logic [TW-1:0]    tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  counter_t         count_q  [ENTRIES];

  logic [IW-1:0] lk_idx, up_idx;
  logic [TW-1:0] lk_tag, up_tag;
  logic          lk_hit, up_hit;

  assign lk_idx = lookup_pc[IW+1:2];
  assign lk_tag = lookup_pc[31:IW+2];
  assign up_idx = upd_pc[IW+1:2];
  assign up_tag = upd_pc[31:IW+2];

  logic unused_upd_low;
  assign unused_upd_low = &{1'b0, upd_pc[1:0]};

  // Lookup reads registered contents, so a same-cycle update is not visible yet.
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign pred_taken  = lk_hit && count_q[lk_idx][1];
  assign pred_target = lk_hit ? target_q[lk_idx] : lookup_pc + 32'd4;
  assign pred_count  = lk_hit ? count_q[lk_idx] : WEAK_NT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        count_q[i]  <= WEAK_NT;
      end
    end else if (upd_valid) begin
      target_q[up_idx] <= upd_target;
      if (up_hit) begin
        count_q[up_idx] <= next_count(count_q[up_idx], upd_taken);
      end else begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        count_q[up_idx] <= upd_taken ? WEAK_T : WEAK_NT;
      end
    end
  end

endmodule

// File: rtl/fetch_predict.sv
// Fetch stage: PC register, instruction-memory handshake, BTB-driven next-PC
// selection and the registered hand-off to decode.
module fetch_predict
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int          BTB_ENTRIES = DEFAULT_BTB_ENTRIES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic        FREEZE,
  input  logic        Request_Alt_PC,
  input  logic [31:0] Alt_PC,
  input  logic [31:0] IM_Data,
  input  logic        IM_Valid,
  input  logic        Upd_Valid,
  input  logic [31:0] Upd_PC,
  input  logic [31:0] Upd_Target,
  input  logic        Upd_Taken,
  output logic [31:0] IM_Addr,
  output logic        IM_Req,
  output logic [31:0] Instr_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT,
  output logic        Branch_prediction_OUT,
  output logic [31:0] Branch_prediction_addr_OUT,
  output logic [1:0]  Branch_predictions_OUT
);

  logic [31:0] pc_q, pc_d, pc_plus4, pred_target;
  logic        pred_taken, fetch;
  counter_t    pred_count;

  btb_2bit #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .CLK        (CLK),
    .RESET      (RESET),
    .lookup_pc  (pc_q),
    .upd_valid  (Upd_Valid),
    .upd_pc     (Upd_PC),
    .upd_target (Upd_Target),
    .upd_taken  (Upd_Taken),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .pred_count (pred_count)
  );

  assign pc_plus4 = pc_q + 32'd4;
  assign fetch    = IM_Valid && !FREEZE;
  assign IM_Addr  = pc_q;
  assign IM_Req   = RESET && !FREEZE;

  // A decode redirect wins even while stalled or waiting on memory.
  always_comb begin
    pc_d = pc_q;
    if (Request_Alt_PC)            pc_d = Alt_PC;
    else if (fetch && pred_taken)  pc_d = pred_target;
    else if (fetch)                pc_d = pc_plus4;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // FLUSH beats FREEZE; a memory wait inserts a bubble but keeps the PC outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Instr_OUT                  <= BUBBLE_INSTR;
      Instr_PC_OUT               <= '0;
      Instr_PC_Plus4_OUT         <= '0;
      Branch_prediction_OUT      <= 1'b0;
      Branch_prediction_addr_OUT <= '0;
      Branch_predictions_OUT     <= '0;
    end else if (FLUSH) begin
      Instr_OUT                  <= BUBBLE_INSTR;
      Branch_prediction_OUT      <= 1'b0;
      Branch_prediction_addr_OUT <= '0;
      Branch_predictions_OUT     <= '0;
    end else if (!FREEZE) begin
      if (IM_Valid) begin
        Instr_OUT                  <= IM_Data;
        Instr_PC_OUT               <= pc_q;
        Instr_PC_Plus4_OUT         <= pc_plus4;
        Branch_prediction_OUT      <= pred_taken;
        Branch_prediction_addr_OUT <= pred_target;
        Branch_predictions_OUT     <= pred_count;
      end else begin
        Instr_OUT              <= BUBBLE_INSTR;
        Branch_prediction_OUT  <= 1'b0;
        Branch_predictions_OUT <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_predict.sv
// Randomized scoreboard bench for fetch_predict against a behavioural model of
// the fetch rules and a table-based BTB.
module tb_fetch_predict;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH, FREEZE, Request_Alt_PC, IM_Valid;
  logic        Upd_Valid, Upd_Taken;
  logic [31:0] Alt_PC, IM_Data, Upd_PC, Upd_Target;
  logic [31:0] IM_Addr, Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT;
  logic [31:0] Branch_prediction_addr_OUT;
  logic        IM_Req, Branch_prediction_OUT;
  logic [1:0]  Branch_predictions_OUT;

  fetch_predict dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .FREEZE(FREEZE),
    .Request_Alt_PC(Request_Alt_PC), .Alt_PC(Alt_PC),
    .IM_Data(IM_Data), .IM_Valid(IM_Valid),
    .Upd_Valid(Upd_Valid), .Upd_PC(Upd_PC), .Upd_Target(Upd_Target), .Upd_Taken(Upd_Taken),
    .IM_Addr(IM_Addr), .IM_Req(IM_Req), .Instr_OUT(Instr_OUT),
    .Instr_PC_OUT(Instr_PC_OUT), .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
    .Branch_prediction_OUT(Branch_prediction_OUT),
    .Branch_prediction_addr_OUT(Branch_prediction_addr_OUT),
    .Branch_predictions_OUT(Branch_predictions_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr, ipc, ipc4, paddr, imaddr;
    logic        pred, imreq;
    logic [1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_out;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  logic [31:0] m_pc;
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pc = 32'hBFC0_0000;
    m_out = '{instr: 0, ipc: 0, ipc4: 0, paddr: 0, imaddr: 0, pred: 0, imreq: 0, cnt: 0};
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
  endtask

  // Drive one cycle of inputs and push what the outputs must be after the next edge.
  task automatic applyStimulus(input bit fl, input bit fz, input bit alt, input logic [31:0] apc,
                               input bit v, input logic [31:0] data, input bit uv,
                               input logic [31:0] upc, input logic [31:0] utgt, input bit ut);
    int idx, ui, pcnt;
    bit hit, ptaken;
    logic [31:0] ptgt;
    FLUSH = fl; FREEZE = fz; Request_Alt_PC = alt; Alt_PC = apc; IM_Valid = v; IM_Data = data;
    Upd_Valid = uv; Upd_PC = upc; Upd_Target = utgt; Upd_Taken = ut;

    idx    = int'((m_pc >> 2) % 16);
    hit    = m_valid[idx] && (m_tag[idx] == (m_pc >> 6));
    ptaken = hit && (m_cnt[idx] >= 2);
    ptgt   = hit ? m_tgt[idx] : m_pc + 32'd4;
    pcnt   = hit ? m_cnt[idx] : 1;

    if (fl) begin
      m_out.instr = 0; m_out.pred = 0; m_out.paddr = 0; m_out.cnt = 0;
    end else if (!fz) begin
      if (v) begin
        m_out.instr = data; m_out.ipc = m_pc; m_out.ipc4 = m_pc + 32'd4;
        m_out.pred = ptaken; m_out.paddr = ptgt; m_out.cnt = 2'(pcnt);
      end else begin
        m_out.instr = 0; m_out.pred = 0; m_out.cnt = 0;
      end
    end

    if (alt)                 m_pc = apc;
    else if (v && !fz && ptaken) m_pc = ptgt;
    else if (v && !fz)       m_pc = m_pc + 32'd4;

    if (uv) begin
      ui = int'((upc >> 2) % 16);
      if (m_valid[ui] && m_tag[ui] == (upc >> 6)) begin
        m_cnt[ui] = ut ? ((m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1)
                       : ((m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1);
      end else begin
        m_valid[ui] = 1; m_tag[ui] = upc >> 6; m_cnt[ui] = ut ? 2 : 1;
      end
      m_tgt[ui] = utgt;
    end

    m_out.imaddr = m_pc;
    m_out.imreq  = !fz;
    exp_q.push_back(m_out);
  endtask

  function automatic logic [31:0] randPc();
    if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFF8 + (32'($urandom_range(0, 1)) << 2);
    return 32'h0040_0000 + (32'($urandom_range(0, 31)) << 2);
  endfunction

  task automatic randomStep();
    applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0, randPc(), $urandom_range(0, 9) < 7, $urandom,
                  $urandom_range(0, 9) < 3, randPc(), randPc(), $urandom_range(0, 1) == 1);
  endtask

  task automatic checkResetState();
    checkOutput("rst_im_addr", IM_Addr, 32'hBFC0_0000);
    checkOutput("rst_im_req", 32'(IM_Req), 32'd0);
    checkOutput("rst_instr", Instr_OUT, 32'd0);
    checkOutput("rst_ipc", Instr_PC_OUT, 32'd0);
    checkOutput("rst_ipc4", Instr_PC_Plus4_OUT, 32'd0);
    checkOutput("rst_pred", 32'(Branch_prediction_OUT), 32'd0);
    checkOutput("rst_paddr", Branch_prediction_addr_OUT, 32'd0);
    checkOutput("rst_cnt", 32'(Branch_predictions_OUT), 32'd0);
  endtask

  // Monitor: one expected record per edge while out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("im_addr", IM_Addr, e.imaddr);
        checkOutput("im_req", 32'(IM_Req), 32'(e.imreq));
        checkOutput("instr", Instr_OUT, e.instr);
        checkOutput("instr_pc", Instr_PC_OUT, e.ipc);
        checkOutput("instr_pc4", Instr_PC_Plus4_OUT, e.ipc4);
        checkOutput("pred", 32'(Branch_prediction_OUT), 32'(e.pred));
        checkOutput("pred_addr", Branch_prediction_addr_OUT, e.paddr);
        checkOutput("pred_cnt", 32'(Branch_predictions_OUT), 32'(e.cnt));
      end
    end
  end

  initial begin
    RESET = 0; FLUSH = 0; FREEZE = 0; Request_Alt_PC = 0; Alt_PC = 0; IM_Data = 0;
    IM_Valid = 0; Upd_Valid = 0; Upd_PC = 0; Upd_Target = 0; Upd_Taken = 0;
    modelReset();
    repeat (2) @(negedge CLK);
    #1 checkResetState();

    @(negedge CLK);
    RESET = 1; mon_en = 1;
    applyStimulus(0, 0, 0, 0, 1, 32'h2402_0005, 0, 0, 0, 0);
    @(posedge CLK); #3;
    checkOutput("first_instr", Instr_OUT, 32'h2402_0005);
    checkOutput("first_ipc", Instr_PC_OUT, 32'hBFC0_0000);
    checkOutput("first_ipc4", Instr_PC_Plus4_OUT, 32'hBFC0_0004);
    checkOutput("first_im_addr", IM_Addr, 32'hBFC0_0004);

    repeat (3) begin @(negedge CLK); applyStimulus(0, 0, 0, 0, 1, $urandom, 0, 0, 0, 0); end
    repeat (3) begin @(negedge CLK); applyStimulus(0, 1, 0, 0, 1, $urandom, 0, 0, 0, 0); end
    repeat (2) begin @(negedge CLK); applyStimulus(0, 0, 0, 0, 1, $urandom, 0, 0, 0, 0); end
    @(negedge CLK); applyStimulus(0, 1, 1, 32'h0040_0100, 1, $urandom, 0, 0, 0, 0);
    repeat (2) begin
      @(negedge CLK); applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0010, 32'hBFC0_0040, 1);
    end
    @(negedge CLK); applyStimulus(0, 0, 1, 32'hBFC0_0010, 0, 0, 0, 0, 0, 0);
    @(negedge CLK); applyStimulus(0, 0, 0, 0, 1, $urandom, 0, 0, 0, 0);
    @(posedge CLK); #3;
    checkOutput("btb_pred", 32'(Branch_prediction_OUT), 32'd1);
    checkOutput("btb_cnt", 32'(Branch_predictions_OUT), 32'd3);
    checkOutput("btb_addr", Branch_prediction_addr_OUT, 32'hBFC0_0040);
    checkOutput("btb_next_pc", IM_Addr, 32'hBFC0_0040);
    @(negedge CLK); applyStimulus(0, 0, 0, 0, 1, $urandom, 0, 0, 0, 0);
    @(negedge CLK); applyStimulus(1, 1, 0, 0, 1, $urandom, 0, 0, 0, 0);
    @(negedge CLK); applyStimulus(0, 0, 1, 32'h0040_0010, 0, 0, 0, 0, 0, 0);
    @(negedge CLK); applyStimulus(0, 0, 1, 32'h0040_0010, 1, $urandom, 1, 32'h0040_0010, 32'h0040_0200, 1);
    @(negedge CLK); applyStimulus(0, 0, 0, 0, 1, $urandom, 0, 0, 0, 0);

    repeat (400) begin @(negedge CLK); randomStep(); end

    @(negedge CLK);
    FLUSH = 1; FREEZE = 1; Request_Alt_PC = 1; Alt_PC = 32'h1234_5678; Upd_Valid = 1; Upd_PC = 32'h0040_0000;
    #2 RESET = 0; mon_en = 0;
    exp_q.delete();
    modelReset();
    #1 checkResetState();
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1; mon_en = 1;
    repeat (100) begin randomStep(); @(negedge CLK); end

    @(posedge CLK); #3;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
